// File: rtl/data_memory_unit.sv
// Word data memory with wait-state handshake, stall and alignment fault.
// Define MEMORY_BYTE_ACCESS_EN to add byte-lane loads and stores.
module data_memory_unit #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memory_request,
    input  logic        memory_write,
    input  logic        byte_access,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        done,
    output logic        alignment_fault
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESPOND
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          write_q, write_d;
    logic [31:0]   read_data_q, read_data_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [AW+1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic          cur_write;
    logic          cur_byte;
    logic [AW-1:0] idx;
    logic [31:0]   old_word;
    logic          misaligned;
    logic          commit;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic          unused_in;

`ifdef MEMORY_BYTE_ACCESS_EN
    logic          byte_q, byte_d;
    logic [7:0]    lane_byte;
    assign unused_in = ^address[31:AW+2];
`else
    assign unused_in = ^{address[31:AW+2], byte_access};
`endif

    always_comb begin
        // In IDLE the live inputs drive a zero-wait commit directly.
        cur_addr  = (state_q == IDLE) ? address[AW+1:0] : addr_q;
        cur_wdata = (state_q == IDLE) ? write_data : wdata_q;
        cur_write = (state_q == IDLE) ? memory_write : write_q;
`ifdef MEMORY_BYTE_ACCESS_EN
        cur_byte  = (state_q == IDLE) ? byte_access : byte_q;
        byte_d    = byte_q;
`else
        cur_byte  = 1'b0;
`endif
        idx        = cur_addr[AW+1:2];
        old_word   = mem_q[idx];
        misaligned = ~cur_byte & (cur_addr[1:0] != 2'b00);

        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        commit  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (memory_request) begin
                    addr_d  = cur_addr;
                    wdata_d = cur_wdata;
                    write_d = cur_write;
`ifdef MEMORY_BYTE_ACCESS_EN
                    byte_d  = cur_byte;
`endif
                    if (misaligned) begin
                        state_d = RESPOND;
                    end else if (WAIT_STATES == 0) begin
                        state_d = RESPOND;
                        commit  = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (!memory_request) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESPOND;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        done_d  = (state_d == RESPOND);
        fault_d = (state_q == IDLE) & memory_request & misaligned;

        mem_we      = commit & cur_write;
        mem_wdata   = cur_wdata;
        read_data_d = read_data_q;
`ifdef MEMORY_BYTE_ACCESS_EN
        lane_byte = old_word[{cur_addr[1:0], 3'b000} +: 8];
        if (cur_byte) begin
            mem_wdata = old_word;
            mem_wdata[{cur_addr[1:0], 3'b000} +: 8] = cur_wdata[7:0];
        end
        if (commit & ~cur_write) begin
            read_data_d = cur_byte ? {24'd0, lane_byte} : old_word;
        end
`else
        if (commit & ~cur_write) begin
            read_data_d = old_word;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            read_data_q <= '0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
`ifdef MEMORY_BYTE_ACCESS_EN
            byte_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            read_data_q <= read_data_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
`ifdef MEMORY_BYTE_ACCESS_EN
            byte_q      <= byte_d;
`endif
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[idx] <= mem_wdata;
        end
    end

    assign read_data       = read_data_q;
    assign done            = done_q;
    assign alignment_fault = fault_q;
    assign stall           = memory_request & ~done_q;

endmodule

// File: tb/tb_data_memory_unit.sv
// Randomised bench for data_memory_unit with a transaction-level reference
// model, a per-cycle compare process and directed literal checks.
module tb_data_memory_unit;
    localparam int DEPTH = 64;
    localparam int W     = 2;
`ifdef MEMORY_BYTE_ACCESS_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        memory_request = 1'b0;
    logic        memory_write = 1'b0;
    logic        byte_access = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        stall, done, alignment_fault;

    logic        z_req = 1'b0;
    logic [31:0] z_rd;
    logic        z_stall, z_done, z_fault;

    data_memory_unit #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(W)) dut (
        .clock(clock), .reset(reset), .memory_request(memory_request),
        .memory_write(memory_write), .byte_access(byte_access),
        .address(address), .write_data(write_data), .read_data(read_data),
        .stall(stall), .done(done), .alignment_fault(alignment_fault)
    );

    data_memory_unit #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_w0 (
        .clock(clock), .reset(reset), .memory_request(z_req),
        .memory_write(1'b0), .byte_access(1'b0),
        .address(32'h8), .write_data(32'h0), .read_data(z_rd),
        .stall(z_stall), .done(z_done), .alignment_fault(z_fault)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference model state
    logic [31:0] mem_m [DEPTH];
    logic [31:0] rd_m = '0;
    int          done_cyc = -5;
    bit          p_write, p_byte, p_mis;
    logic [31:0] p_addr, p_data;

    // Per-access observations
    int          stall_n, done_off, done_abs;
    bit          fault_seen, stall_at_done, done_seen;
    logic [31:0] rd_at_done;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_mis(input bit b, input logic [31:0] a);
        return !(BYTE_EN && b) && (a[1:0] != 2'b00);
    endfunction

    always @(negedge clock) begin
        bit ed;
        int ix, ln;
        ed = (cyc == done_cyc);
        ix = int'((p_addr >> 2) % DEPTH);
        ln = int'(p_addr[1:0]);
        if (ed && !p_mis) begin
            if (p_write) begin
                if (p_byte) mem_m[ix][ln*8 +: 8] = p_data[7:0];
                else        mem_m[ix] = p_data;
            end else begin
                rd_m = p_byte ? ((mem_m[ix] >> (ln * 8)) & 32'hFF)
                              : mem_m[ix];
            end
        end
        chk("cmp_done", {31'd0, done}, {31'd0, ed});
        chk("cmp_fault", {31'd0, alignment_fault}, {31'd0, ed && p_mis});
        chk("cmp_rdata", read_data, rd_m);
        chk("cmp_stall", {31'd0, stall}, {31'd0, memory_request && !ed});
    end

    // Entered at posedge+1; leaves at posedge+1 of the cycle after done.
    task automatic access(input bit w, input bit b, input logic [31:0] a,
                          input logic [31:0] d, input int abort_k);
        int lat;
        memory_request = 1'b1;
        memory_write   = w;
        byte_access    = b;
        address        = a;
        write_data     = d;
        p_write = w;
        p_byte  = BYTE_EN && b;
        p_addr  = a;
        p_data  = d;
        p_mis   = is_mis(b, a);
        lat     = p_mis ? 1 : W + 1;
        done_cyc = cyc + lat;
        stall_n = 0;
        done_off = -1;
        done_abs = -1;
        fault_seen = 1'b0;
        stall_at_done = 1'b0;
        done_seen = 1'b0;
        rd_at_done = '0;
        for (int k = 0; k <= lat; k++) begin
            if (abort_k >= 0 && k == abort_k) begin
                memory_request = 1'b0;
                done_cyc = -5;
            end
            #3;
            if (stall) stall_n++;
            if (done && !done_seen) begin
                done_seen = 1'b1;
                done_off = k;
                done_abs = cyc;
                fault_seen = alignment_fault;
                stall_at_done = stall;
                rd_at_done = read_data;
            end
            @(posedge clock);
            #1;
        end
        memory_request = 1'b0;
    endtask

    initial begin
        int d0, d1, ak, zpat, zst;
        bit w, b;
        logic [31:0] a, dd;

        repeat (2) @(posedge clock);
        #1;
        chk("reset_rdata", read_data, 32'h0);
        chk("reset_done", {31'd0, done}, 32'h0);
        chk("reset_fault", {31'd0, alignment_fault}, 32'h0);
        chk("reset_stall", {31'd0, stall}, 32'h0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < DEPTH; i++) access(1'b1, 1'b0, i * 4, $urandom, -1);

        access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, -1);
        chk("store_stall_cycles", stall_n, 3);
        chk("store_done_offset", done_off, 3);
        access(1'b0, 1'b0, 32'h10, 32'h0, -1);
        chk("load_10", rd_at_done, 32'hDEADBEEF);
        chk("load_stall_at_done", {31'd0, stall_at_done}, 32'h0);

        access(1'b0, 1'b0, 32'h13, 32'h0, -1);
        chk("mis_load_fault", {31'd0, fault_seen}, 32'h1);
        chk("mis_load_offset", done_off, 1);
        chk("mis_load_rdata", rd_at_done, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h13, 32'h0, -1);
        access(1'b0, 1'b0, 32'h10, 32'h0, -1);
        chk("mis_store_nowrite", rd_at_done, 32'hDEADBEEF);

        access(1'b1, 1'b0, 32'h104, 32'h12345678, -1);
        access(1'b0, 1'b0, 32'h004, 32'h0, -1);
        chk("wrap_load", rd_at_done, 32'h12345678);

        access(1'b0, 1'b0, 32'h10, 32'h0, -1);
        d0 = done_abs;
        access(1'b0, 1'b0, 32'h004, 32'h0, -1);
        d1 = done_abs;
        chk("back_to_back_gap", d1 - d0, 4);

        access(1'b1, 1'b0, 32'h20, 32'h0BADF00D, -1);
        memory_request = 1'b1;
        memory_write = 1'b1;
        byte_access = 1'b0;
        address = 32'h20;
        write_data = 32'hAAAA5555;
        p_write = 1'b1; p_byte = 1'b0; p_mis = 1'b0;
        p_addr = 32'h20; p_data = 32'hAAAA5555;
        done_cyc = cyc + W + 1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        memory_request = 1'b0;
        done_cyc = -5;
        rd_m = '0;
        #3;
        chk("midreset_rdata", read_data, 32'h0);
        chk("midreset_done", {31'd0, done}, 32'h0);
        chk("midreset_fault", {31'd0, alignment_fault}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        access(1'b0, 1'b0, 32'h20, 32'h0, -1);
        chk("after_reset_load", rd_at_done, 32'h0BADF00D);

        access(1'b1, 1'b0, 32'h24, 32'h01020304, -1);
        access(1'b1, 1'b0, 32'h24, 32'hFFFFFFFF, 1);
        chk("abort_no_done", {31'd0, done_seen}, 32'h0);
        access(1'b0, 1'b0, 32'h24, 32'h0, -1);
        chk("abort_no_write", rd_at_done, 32'h01020304);

`ifdef MEMORY_BYTE_ACCESS_EN
        access(1'b1, 1'b0, 32'h30, 32'h11223344, -1);
        access(1'b1, 1'b1, 32'h32, 32'hABCDEFEE, -1);
        chk("byte_store_nofault", {31'd0, fault_seen}, 32'h0);
        access(1'b0, 1'b0, 32'h30, 32'h0, -1);
        chk("byte_store_merge", rd_at_done, 32'h11EE3344);
        access(1'b0, 1'b1, 32'h33, 32'h0, -1);
        chk("byte_load_zext", rd_at_done, 32'h00000011);
`else
        access(1'b0, 1'b1, 32'h33, 32'h0, -1);
        chk("byte_ignored_fault", {31'd0, fault_seen}, 32'h1);
`endif

        for (int n = 0; n < 250; n++) begin
            w = 1'($urandom);
            b = 1'($urandom);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            dd = $urandom;
            ak = -1;
            if (W > 0 && !is_mis(b, a) && $urandom_range(0, 7) == 0)
                ak = $urandom_range(1, W);
            access(w, b, a, dd, ak);
            repeat ($urandom_range(0, 1)) begin
                @(posedge clock);
                #1;
            end
        end

        zpat = 0;
        zst = 0;
        z_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #3;
            if (z_done) zpat |= (1 << k);
            if (z_stall) zst++;
            @(posedge clock);
            #1;
        end
        z_req = 1'b0;
        chk("w0_done_pattern", zpat, 32'h2A);
        chk("w0_stall_cycles", zst, 3);

        repeat (2) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_memory_unit.md
Name: data_memory_unit

Overview:
- Word-organised data memory with a configurable wait-state handshake.
- Sits directly downstream of the processor datapath: consumes the ALU result as the address and register-file read port 2 as store data, and returns load data to the result mux.
- Raises a stall so the control unit freezes the PC and register writes until the access completes.
- Flags misaligned word accesses.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the array (power of two, >= 2).
- WAIT_STATES, 2, extra cycles spent in BUSY per access (0..15).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- memory_request  input  1  load/store requested by the current instruction; held stable while stall=1.
- memory_write  input  1  1 = store, 0 = load; sampled with the request.
- byte_access  input  1  byte-sized access; honoured only with MEMORY_BYTE_ACCESS_EN.
- address  input  32  byte address (datapath alu_result).
- write_data  input  32  store data (datapath register_file_out2).
- read_data  output  32  load result, registered.
- stall  output  1  combinational: memory_request & ~done.
- done  output  1  one-cycle completion pulse.
- alignment_fault  output  1  valid with done; misaligned word access.

Behaviour:
- Reset values: state=IDLE, read_data=0, done=0, alignment_fault=0, wait counter=0. Array contents are NOT reset.
- Word index = address[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Address, write_data, memory_write and byte_access are captured on the IDLE->BUSY or IDLE->RESPOND edge.
- FSM states: IDLE, BUSY, RESPOND.
- IDLE:
  - No request: stay in IDLE.
  - Request, word access with address[1:0]!=0: go to RESPOND with fault=1; BUSY is skipped.
  - Request, WAIT_STATES==0: go to RESPOND.
  - Request, otherwise: go to BUSY with counter=WAIT_STATES-1.
- BUSY:
  - Counter decrements each cycle; go to RESPOND when counter==0.
  - memory_request falling to 0: abort to IDLE, no array write, read_data unchanged.
- RESPOND:
  - done=1 for exactly one cycle; alignment_fault is driven here only.
  - Always returns to IDLE, even if memory_request is still high (that request belongs to the next instruction).
- Latency: request first seen in IDLE at cycle t gives done at t+WAIT_STATES+1. A misaligned access gives done at t+1. Back-to-back accesses therefore carry a one-cycle IDLE gap.
- Loads: read_data is loaded from the array on the edge entering RESPOND and held until the next completed non-faulting load.
- Stores: the array word is written on the edge entering RESPOND. A load issued immediately afterwards to the same address returns the new value.
- Faulting access: no array write, read_data unchanged.
- Reset mid-operation: FSM returns to IDLE immediately. Any store not yet committed is discarded.

Optional Feature:
- Macro: MEMORY_BYTE_ACCESS_EN.
- Defined:
  - byte_access=1 never faults.
  - Byte store writes write_data[7:0] into lane address[1:0] (lane 0 = bits 7:0); the other three lanes are preserved.
  - Byte load returns the selected byte zero-extended to 32 bits.
- Undefined:
  - byte_access is ignored; every access is a word access with the alignment check applied.
  - No byte-lane logic is synthesised.

Test Plan:
- WAIT_STATES=2: store 0xDEADBEEF to 0x10, request at cycle 0 -> stall=1 cycles 0-2, done at cycle 3. Then load 0x10 -> read_data=0xDEADBEEF with done, stall low that cycle.
- WAIT_STATES=0: load request -> done the following cycle, stall high for exactly one cycle. Two consecutive requests -> second done two cycles after the first.
- Word load at 0x13 -> done and alignment_fault=1 one cycle after the request, read_data unchanged. Word store to 0x13 -> array unchanged (verified by an aligned load of 0x10).
- DEPTH_WORDS=64: store 0x12345678 to 0x104 -> load from 0x004 returns 0x12345678 (wrap-around).
- Store 0xAAAA5555 to 0x20 with reset pulsed during BUSY -> outputs return to reset values. A subsequent load of 0x20 returns the prior contents. Drop memory_request mid-BUSY -> no done pulse.
- With MEMORY_BYTE_ACCESS_EN: word 0x11223344 at 0x30, byte store 0xEE to 0x32 -> word reads 0x11EE3344. Byte load 0x33 -> 0x00000011. Without the macro, a byte load at 0x33 -> alignment_fault=1.
